hex_display_reader: RTL

- Inverse of the team's hex-to-7-segment decoder: snoops a multiplexed active-low 7-segment bus and recovers the hex value being shown.
- Per-digit patterns must be stable before acceptance. Digits are assembled into a multi-digit word and handed off through a valid/ready interface.
- Used as a self-check monitor on display outputs and as a loopback path for board tests.

---
 rtl/hex_display_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hex_display_reader.sv
// hex_display_reader
//   Snoops a multiplexed, active-low 7-segment display bus and recovers the
//   hex word being shown. Each digit pattern has to be held unchanged for
//   STABLE_CYCLES consecutive one-hot strobe cycles before it is accepted.
//   Accepted digits are assembled into a NUM_DIGITS-nibble word. The word is
//   offered on a valid/ready interface once every digit has been seen.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digits (1..8)
//   STABLE_CYCLES  identical qualifying cycles needed to accept a digit (>=1)
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   seg         segment pattern, active-low, bit0=a .. bit6=g
//   dig_en      one-hot digit strobe, bit i = nibble i of value
//   out_ready   consumer ready
//   out_valid   assembled frame available
//   value       assembled hex word
//   bad_mask    bit i set: digit i pattern was not recognised
//   blank_mask  bit i set: digit i was blank (BLANK_DECODE_EN only, else 0)
//   dropped     sticky: a digit was accepted while a frame was pending
//
// Build option
//   `define BLANK_DECODE_EN : all-segments-off decodes as a valid blank digit
//                             (nibble 0, blank bit set) instead of a bad one.

module hex_display_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   bad_mask,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    dropped
);

    localparam int              CW      = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
    localparam int              SW      = NUM_DIGITS + 7;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]            state;
    logic [NUM_DIGITS-1:0] seen;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [SW-1:0]         prev;
    logic                  qual;
    logic                  same;
    logic                  accept;
    logic [3:0]            nib;
    logic                  bad;
`ifdef BLANK_DECODE_EN
    logic                  blank;
    logic [NUM_DIGITS-1:0] blank_r;
`endif

    // Inverse of the hex-to-7-segment table.
    always_comb begin
        nib = 4'h0;
        bad = 1'b0;
`ifdef BLANK_DECODE_EN
        blank = 1'b0;
`endif
        case (seg)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
`ifdef BLANK_DECODE_EN
            7'b1111111: blank = 1'b1;
`endif
            default:    bad = 1'b1;
        endcase
    end

    // A run is "same" only if the previous cycle also qualified (cnt != 0).
    // The accept fires on the edge that takes the count to STABLE_CYCLES.
    // A saturated count never re-fires until the input changes.
    always_comb begin
        qual = (dig_en != '0) && ((dig_en & (dig_en - 1'b1)) == '0);
        same = qual && ({dig_en, seg} == prev) && (cnt != '0);
        if (!qual) begin
            cnt_next = '0;
        end else if (same) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end else begin
            cnt_next = CW'(1);
        end
        accept = qual && (same ? (cnt == CNT_MAX - 1'b1) : (STABLE_CYCLES == 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= COLLECT;
            seen     <= '0;
            cnt      <= '0;
            prev     <= '0;
            value    <= '0;
            bad_mask <= '0;
            dropped  <= 1'b0;
`ifdef BLANK_DECODE_EN
            blank_r  <= '0;
`endif
        end else begin
            prev <= {dig_en, seg};
            cnt  <= cnt_next;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                            if (dig_en[i]) begin
                                value[4*i +: 4] <= nib;
                                bad_mask[i]     <= bad;
`ifdef BLANK_DECODE_EN
                                blank_r[i]      <= blank;
`endif
                            end
                        end
                        if ((seen | dig_en) == '1) begin
                            state <= PRESENT;
                            seen  <= '0;
                        end else begin
                            seen <= seen | dig_en;
                        end
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        dropped <= 1'b1;
                    end
                    if (out_ready) begin
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign out_valid = (state == PRESENT);

`ifdef BLANK_DECODE_EN
    assign blank_mask = blank_r;
`else
    assign blank_mask = '0;
`endif

endmodule
